obstacle_pass_scorer: RTL

- Sits directly upstream of the score counter and drives its `score_increment` input.
- Once per frame, checks every obstacle against the player row. Each obstacle that passes the player in a different lane earns one credit.
- Credits are queued and emitted as clean one-cycle pulses separated by a low cycle, so the downstream rising-edge detector never misses a point, even when several obstacles pass in the same frame.

---
 rtl/obstacle_pass_scorer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/obstacle_pass_scorer.sv
// Purpose: credits obstacles that pass the player row in another lane, then meters the credits out as spaced score pulses.
// Latency: a credited frame_tick at cycle T raises score_increment at T+2 when idle; pulses repeat every 3 cycles.
// Backpressure: none downstream; credits queue in a saturating counter and excess credits are dropped. Optional: MULTI_PASS_BONUS_EN.
module obstacle_pass_scorer #(
  parameter int NUM_OBST = 4,
  parameter int Y_W      = 7,
  parameter int PLAYER_Y = 100,
  parameter int PEND_W   = 4
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  game_active,
  input  logic                  frame_tick,
  input  logic [NUM_OBST-1:0]   obst_valid,
  input  logic [NUM_OBST*Y_W-1:0] obst_y,
  input  logic [NUM_OBST*2-1:0] obst_lane,
  input  logic [1:0]            player_lane,
  output logic                  score_increment,
  output logic [PEND_W-1:0]     pending,
  output logic                  busy
`ifdef MULTI_PASS_BONUS_EN
  ,
  output logic                  bonus_flag
`endif
);

  localparam int CNT_W = $clog2(NUM_OBST + 1);
  // One extra bit leaves room for the optional bonus credit.
  localparam int ADD_W = CNT_W + 1;
  localparam int SUM_W = ((PEND_W > ADD_W) ? PEND_W : ADD_W) + 1;
  localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'({PEND_W{1'b1}});
  localparam logic [Y_W-1:0]   PLAYER_Y_V = Y_W'(PLAYER_Y);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t              state, state_next;
  logic [NUM_OBST-1:0] passed, passed_next;
  logic [NUM_OBST-1:0] beyond, lane_diff, new_pass, credit;
  logic [CNT_W-1:0]    new_credits;
  logic [ADD_W-1:0]    add_credits;
  logic                bonus_grant;
  logic                sample;
  logic                dec;
  logic [SUM_W-1:0]    sum_wide, pend_wide;
  logic [PEND_W-1:0]   pending_next;

  assign sample = frame_tick & game_active;

  genvar g;
  generate
    for (g = 0; g < NUM_OBST; g++) begin : g_slot
      assign beyond[g]    = obst_y[g*Y_W +: Y_W] > PLAYER_Y_V;
      assign lane_diff[g] = obst_lane[g*2 +: 2] != player_lane;
    end
  endgenerate

  // Per-slot pass detection, once-per-descent flags and credit popcount.
  always_comb begin
    new_pass    = '0;
    credit      = '0;
    passed_next = passed;
    new_credits = '0;
    for (int i = 0; i < NUM_OBST; i++) begin
      new_pass[i] = sample & obst_valid[i] & ~passed[i] & beyond[i];
      credit[i]   = new_pass[i] & lane_diff[i];
      if (sample) begin
        if (!obst_valid[i] || !beyond[i]) passed_next[i] = 1'b0;
        else if (new_pass[i])             passed_next[i] = 1'b1;
      end
      new_credits = new_credits + CNT_W'(credit[i]);
    end
  end

  // Credits added this cycle, including the multi-pass bonus when built in.
  always_comb begin
`ifdef MULTI_PASS_BONUS_EN
    bonus_grant = {1'b0, new_credits} >= ADD_W'(2);
`else
    bonus_grant = 1'b0;
`endif
    add_credits = {1'b0, new_credits} + ADD_W'(bonus_grant);
  end

  // Output FSM next state plus the saturating pending update; dec fires on leaving IDLE.
  always_comb begin
    state_next = state;
    dec        = 1'b0;
    sum_wide   = SUM_W'(pending) + SUM_W'(add_credits);
    case (state)
      IDLE: begin
        if (sum_wide != '0) begin
          dec        = 1'b1;
          state_next = PULSE;
        end
      end
      PULSE:   state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    pend_wide    = sum_wide - SUM_W'(dec);
    pending_next = (pend_wide > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : pend_wide[PEND_W-1:0];
  end

  // State registers; reset or an inactive game flushes everything, truncating any pulse.
  always_ff @(posedge Clock) begin
    if (!Resetn || !game_active) begin
      state           <= IDLE;
      pending         <= '0;
      passed          <= '0;
      score_increment <= 1'b0;
    end else begin
      state           <= state_next;
      pending         <= pending_next;
      passed          <= passed_next;
      // Registered copy of PULSE keeps the output glitch-free and one cycle wide.
      score_increment <= (state == PULSE);
    end
  end

`ifdef MULTI_PASS_BONUS_EN
  // Bonus indicator follows the granting tick by one cycle.
  always_ff @(posedge Clock) begin
    if (!Resetn || !game_active) bonus_flag <= 1'b0;
    else                         bonus_flag <= bonus_grant;
  end
`endif

  assign busy = (pending != '0) || (state != IDLE);

endmodule
